// File: rtl/tr_pcs_pkg.sv
// tr_pcs_pkg: shared types, sync-header codes and helpers for the 10GBASE-R receive PCS
package tr_pcs_pkg;

   typedef enum logic [2:0] {RESET_CNT, TEST_SH, SLIP, SLIP_WAIT} lock_state_t;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   function automatic logic sh_is_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage

// File: rtl/tr_sync2.sv
// tr_sync2: two-flop synchronizer for a single asynchronous level
module tr_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;

   // shift the async level through two flops to settle metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], d};
   end

   assign q = sync_q[1];

endmodule

// File: rtl/tr_block_lock_ctrl.sv
// tr_block_lock_ctrl: 10GBASE-R block-lock FSM driving PMA bit-slip until sync headers align
module tr_block_lock_ctrl #(
   parameter int SH_CNT_MAX   = 64,
   parameter int SH_INVLD_MAX = 16,
   parameter int SLIP_WIDTH   = 2,
   parameter int SLIP_WAIT    = 32
) (
   input  logic        clk_glbl,
   input  logic        rst_glbl_n,
   input  logic        rx_rdy,
   input  logic        hdr_valid,
   input  logic [1:0]  hdr,
   output logic        pma_slip,
   output logic        block_lock,
   output logic [6:0]  slip_cnt,
   output logic [15:0] lock_loss_cnt
);

   import tr_pcs_pkg::*;

   localparam int SHW = $clog2(SH_CNT_MAX + 1);
   localparam int IVW = $clog2(SH_INVLD_MAX + 1);
   localparam int TW  = $clog2(((SLIP_WAIT > SLIP_WIDTH) ? SLIP_WAIT : SLIP_WIDTH) + 1);

   lock_state_t    state_q, state_d;
   logic [SHW-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
   logic [IVW-1:0] invld_q, invld_d, invld_inc;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           block_lock_q, block_lock_d;
   logic           pma_slip_q, pma_slip_d;
   logic [6:0]     slip_cnt_q, slip_cnt_d, slip_cnt_inc;
   logic [15:0]    lock_loss_q, lock_loss_d, lock_loss_inc;
   logic           rx_rdy_s, hdr_ok, lose, slip_req, win_done, slip_last, wait_last;

   tr_sync2 u_sync_rdy (
      .clk   (clk_glbl),
      .rst_n (rst_glbl_n),
      .d     (rx_rdy),
      .q     (rx_rdy_s)
   );

   assign hdr_ok        = sh_is_valid(hdr);
   assign sh_cnt_inc    = sh_cnt_q + SHW'(1);
   assign invld_inc     = invld_q + IVW'(!hdr_ok);
   assign slip_cnt_inc  = (slip_cnt_q == 7'd65) ? 7'd0 : slip_cnt_q + 7'd1;
   assign lock_loss_inc = lock_loss_q + 16'(lock_loss_q != 16'hFFFF);
   assign lose          = block_lock_q && (invld_inc == IVW'(SH_INVLD_MAX));
   assign slip_req      = lose || (!block_lock_q && !hdr_ok);
   assign win_done      = sh_cnt_inc == SHW'(SH_CNT_MAX);
   assign slip_last     = tmr_q == TW'(SLIP_WIDTH - 1);
   assign wait_last     = tmr_q == TW'(SLIP_WAIT - 1);

   // next-state and next-output logic; a deasserted synced rx_rdy overrides every state
   always_comb begin
      state_d      = state_q;
      sh_cnt_d     = sh_cnt_q;
      invld_d      = invld_q;
      tmr_d        = tmr_q;
      block_lock_d = block_lock_q;
      pma_slip_d   = 1'b0;
      slip_cnt_d   = slip_cnt_q;
      lock_loss_d  = lock_loss_q;
      case (state_q)
         RESET_CNT: begin
            sh_cnt_d = '0;
            invld_d  = '0;
            state_d  = TEST_SH;
         end
         TEST_SH: begin
            if (hdr_valid) begin
               sh_cnt_d = sh_cnt_inc;
               invld_d  = invld_inc;
               if (slip_req) begin
                  state_d      = SLIP;
                  pma_slip_d   = 1'b1;
                  tmr_d        = '0;
                  slip_cnt_d   = slip_cnt_inc;
                  block_lock_d = 1'b0;
                  lock_loss_d  = lose ? lock_loss_inc : lock_loss_q;
               end else if (win_done) begin
                  state_d      = RESET_CNT;
                  block_lock_d = 1'b1;
                  slip_cnt_d   = block_lock_q ? slip_cnt_q : 7'd0;
               end
            end
         end
         SLIP: begin
            block_lock_d = 1'b0;
            pma_slip_d   = !slip_last;
            tmr_d        = slip_last ? '0 : tmr_q + TW'(1);
            state_d      = slip_last ? tr_pcs_pkg::SLIP_WAIT : SLIP;
         end
         tr_pcs_pkg::SLIP_WAIT: begin
            tmr_d   = wait_last ? '0 : tmr_q + TW'(1);
            state_d = wait_last ? RESET_CNT : tr_pcs_pkg::SLIP_WAIT;
         end
         default: state_d = RESET_CNT;
      endcase
      if (!rx_rdy_s) begin
         state_d      = RESET_CNT;
         sh_cnt_d     = '0;
         invld_d      = '0;
         tmr_d        = '0;
         block_lock_d = 1'b0;
         pma_slip_d   = 1'b0;
         lock_loss_d  = block_lock_q ? lock_loss_inc : lock_loss_q;
      end
   end

   // state, counters and registered outputs
   always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
      if (!rst_glbl_n) begin
         state_q      <= RESET_CNT;
         sh_cnt_q     <= '0;
         invld_q      <= '0;
         tmr_q        <= '0;
         block_lock_q <= 1'b0;
         pma_slip_q   <= 1'b0;
         slip_cnt_q   <= '0;
         lock_loss_q  <= '0;
      end else begin
         state_q      <= state_d;
         sh_cnt_q     <= sh_cnt_d;
         invld_q      <= invld_d;
         tmr_q        <= tmr_d;
         block_lock_q <= block_lock_d;
         pma_slip_q   <= pma_slip_d;
         slip_cnt_q   <= slip_cnt_d;
         lock_loss_q  <= lock_loss_d;
      end
   end

   assign pma_slip      = pma_slip_q;
   assign block_lock    = block_lock_q;
   assign slip_cnt      = slip_cnt_q;
   assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_tr_block_lock_ctrl.sv
// tb_tr_block_lock_ctrl: directed scenario tests for the block-lock controller
module tb_tr_block_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_rdy = 1'b1;
   logic        hdr_valid = 1'b0;
   logic [1:0]  hdr = 2'b00;
   logic        pma_slip;
   logic        block_lock;
   logic [6:0]  slip_cnt;
   logic [15:0] lock_loss_cnt;
   int          checks = 0;
   int          errors = 0;

   tr_block_lock_ctrl dut (
      .clk_glbl      (clk),
      .rst_glbl_n    (rst_n),
      .rx_rdy        (rx_rdy),
      .hdr_valid     (hdr_valid),
      .hdr           (hdr),
      .pma_slip      (pma_slip),
      .block_lock    (block_lock),
      .slip_cnt      (slip_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [1:0] h);
      hdr_valid = 1'b1;
      hdr = h;
      cyc(1);
      hdr_valid = 1'b0;
      hdr = 2'b00;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      hdr_valid = 1'b0;
      rx_rdy = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
   endtask

   task automatic acquire;
      for (int i = 0; i < 64; i++) send(i[0] ? 2'b10 : 2'b01);
      cyc(1);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc(2);
      checks++; if (pma_slip !== 1'b0) begin $display("FAIL reset_pma_slip got=%b exp=0", pma_slip); errors++; end
      checks++; if (block_lock !== 1'b0) begin $display("FAIL reset_block_lock got=%b exp=0", block_lock); errors++; end
      checks++; if (slip_cnt !== 7'd0) begin $display("FAIL reset_slip_cnt got=%0d exp=0", slip_cnt); errors++; end
      checks++; if (lock_loss_cnt !== 16'd0) begin $display("FAIL reset_lock_loss got=%0d exp=0", lock_loss_cnt); errors++; end
      checks++; if (dut.state_q !== tr_pcs_pkg::RESET_CNT) begin $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, tr_pcs_pkg::RESET_CNT); errors++; end
   endtask

   task automatic test_lock_acquire;
      int slip_seen = 0;
      do_reset();
      for (int i = 0; i < 63; i++) begin
         send(i[0] ? 2'b10 : 2'b01);
         if (pma_slip) slip_seen++;
      end
      checks++; if (block_lock !== 1'b0) begin $display("FAIL acq_early_lock got=%b exp=0 after 63 headers", block_lock); errors++; end
      send(2'b01);
      if (pma_slip) slip_seen++;
      checks++; if (block_lock !== 1'b1) begin $display("FAIL acq_lock got=%b exp=1 after 64 headers", block_lock); errors++; end
      checks++; if (slip_seen !== 0) begin $display("FAIL acq_no_slip got=%0d slip cycles exp=0", slip_seen); errors++; end
      checks++; if (slip_cnt !== 7'd0) begin $display("FAIL acq_slip_cnt got=%0d exp=0", slip_cnt); errors++; end
   endtask

   task automatic test_slip;
      int late_slip = 0;
      do_reset();
      for (int i = 0; i < 10; i++) send(2'b01);
      send(2'b11);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL slip_start got=%b exp=1", pma_slip); errors++; end
      checks++; if (slip_cnt !== 7'd1) begin $display("FAIL slip_cnt1 got=%0d exp=1", slip_cnt); errors++; end
      for (int i = 1; i <= 35; i++) begin
         send(2'b11);
         if (i == 1) begin
            checks++; if (pma_slip !== 1'b1) begin $display("FAIL slip_second_cycle got=%b exp=1", pma_slip); errors++; end
         end else if (pma_slip) late_slip++;
      end
      checks++; if (late_slip !== 0) begin $display("FAIL slip_width_or_ignore got=%0d extra high cycles exp=0", late_slip); errors++; end
      checks++; if (slip_cnt !== 7'd1) begin $display("FAIL slip_wait_ignore got=%0d exp=1", slip_cnt); errors++; end
      send(2'b11);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL slip_retest got=%b exp=1", pma_slip); errors++; end
      checks++; if (slip_cnt !== 7'd2) begin $display("FAIL slip_cnt2 got=%0d exp=2", slip_cnt); errors++; end
      cyc(40);
   endtask

   task automatic test_lock_hold;
      int drop_seen = 0;
      do_reset();
      acquire();
      for (int i = 0; i < 64; i++) begin
         send(i < 15 ? 2'b00 : 2'b01);
         if (!block_lock || pma_slip) drop_seen++;
      end
      checks++; if (drop_seen !== 0) begin $display("FAIL hold_15_invalid got=%0d bad cycles exp=0", drop_seen); errors++; end
      checks++; if (lock_loss_cnt !== 16'd0) begin $display("FAIL hold_lock_loss got=%0d exp=0", lock_loss_cnt); errors++; end
      cyc(1);
      for (int i = 0; i < 63; i++) send(i < 48 ? 2'b10 : 2'b11);
      checks++; if (block_lock !== 1'b1) begin $display("FAIL hold_before_16th got=%b exp=1", block_lock); errors++; end
      send(2'b11);
      checks++; if (block_lock !== 1'b0) begin $display("FAIL drop_lock got=%b exp=0", block_lock); errors++; end
      checks++; if (lock_loss_cnt !== 16'd1) begin $display("FAIL drop_lock_loss got=%0d exp=1", lock_loss_cnt); errors++; end
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL drop_slip got=%b exp=1", pma_slip); errors++; end
      checks++; if (slip_cnt !== 7'd1) begin $display("FAIL drop_slip_cnt got=%0d exp=1", slip_cnt); errors++; end
      cyc(40);
   endtask

   task automatic test_slip_wrap;
      do_reset();
      for (int n = 1; n <= 70; n++) begin
         send(2'b00);
         if (n == 65) begin
            checks++; if (slip_cnt !== 7'd65) begin $display("FAIL wrap_65 got=%0d exp=65", slip_cnt); errors++; end
         end
         if (n == 66) begin
            checks++; if (slip_cnt !== 7'd0) begin $display("FAIL wrap_66 got=%0d exp=0", slip_cnt); errors++; end
         end
         cyc(40);
      end
      for (int i = 0; i < 63; i++) send(2'b10);
      checks++; if (slip_cnt !== 7'd4) begin $display("FAIL wrap_before_lock got=%0d exp=4", slip_cnt); errors++; end
      send(2'b01);
      checks++; if (block_lock !== 1'b1) begin $display("FAIL wrap_lock got=%b exp=1", block_lock); errors++; end
      checks++; if (slip_cnt !== 7'd0) begin $display("FAIL wrap_after_lock got=%0d exp=0", slip_cnt); errors++; end
   endtask

   task automatic test_rx_rdy_drop;
      do_reset();
      acquire();
      rx_rdy = 1'b0;
      cyc(2);
      checks++; if (block_lock !== 1'b1) begin $display("FAIL rdy_sync_delay got=%b exp=1", block_lock); errors++; end
      cyc(1);
      checks++; if (block_lock !== 1'b0) begin $display("FAIL rdy_drop_lock got=%b exp=0", block_lock); errors++; end
      checks++; if (lock_loss_cnt !== 16'd1) begin $display("FAIL rdy_drop_loss got=%0d exp=1", lock_loss_cnt); errors++; end
      checks++; if (dut.state_q !== tr_pcs_pkg::RESET_CNT) begin $display("FAIL rdy_drop_state got=%0d exp=%0d", dut.state_q, tr_pcs_pkg::RESET_CNT); errors++; end
      rx_rdy = 1'b1;
      cyc(5);
      rx_rdy = 1'b0;
      send(2'b11);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL rdy_mid_slip_start got=%b exp=1", pma_slip); errors++; end
      cyc(2);
      checks++; if (pma_slip !== 1'b0) begin $display("FAIL rdy_mid_slip_pma got=%b exp=0", pma_slip); errors++; end
      checks++; if (dut.state_q !== tr_pcs_pkg::RESET_CNT) begin $display("FAIL rdy_mid_slip_state got=%0d exp=%0d", dut.state_q, tr_pcs_pkg::RESET_CNT); errors++; end
      checks++; if (lock_loss_cnt !== 16'd1) begin $display("FAIL rdy_mid_slip_loss got=%0d exp=1", lock_loss_cnt); errors++; end
      rx_rdy = 1'b1;
      cyc(4);
      send(2'b11);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL rdy_resume_slip got=%b exp=1", pma_slip); errors++; end
      checks++; if (slip_cnt !== 7'd2) begin $display("FAIL rdy_resume_cnt got=%0d exp=2", slip_cnt); errors++; end
      cyc(40);
   endtask

   task automatic test_reset_mid_slip;
      int stray = 0;
      do_reset();
      send(2'b11);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL rst_slip_start got=%b exp=1", pma_slip); errors++; end
      rst_n = 1'b0;
      #1;
      checks++; if (pma_slip !== 1'b0) begin $display("FAIL rst_async_pma got=%b exp=0", pma_slip); errors++; end
      checks++; if (slip_cnt !== 7'd0) begin $display("FAIL rst_async_cnt got=%0d exp=0", slip_cnt); errors++; end
      cyc(2);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (pma_slip) stray++;
      end
      checks++; if (stray !== 0) begin $display("FAIL rst_partial_pulse got=%0d cycles exp=0", stray); errors++; end
      send(2'b00);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL rst_new_slip1 got=%b exp=1", pma_slip); errors++; end
      cyc(1);
      checks++; if (pma_slip !== 1'b1) begin $display("FAIL rst_new_slip2 got=%b exp=1", pma_slip); errors++; end
      cyc(1);
      checks++; if (pma_slip !== 1'b0) begin $display("FAIL rst_new_slip_end got=%b exp=0", pma_slip); errors++; end
      checks++; if (slip_cnt !== 7'd1) begin $display("FAIL rst_new_slip_cnt got=%0d exp=1", slip_cnt); errors++; end
   endtask

   initial begin
      test_reset();
      test_lock_acquire();
      test_slip();
      test_lock_hold();
      test_slip_wrap();
      test_rx_rdy_drop();
      test_reset_mid_slip();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
